// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
//   Sequences every entry of a small register file either out onto a
//   valid/ready dump stream (mode=0) or in from a valid/ready load stream
//   (mode=1). A single index counter walks the entries 0..NUM_REGS-1.
//
//   Optional feature macro: REGFILE_DUMP_LOAD_EN
//     defined   -> LOAD mode present (mode selects DUMP or LOAD)
//     undefined -> mode ignored, start always dumps, in_ready/rf_write tied 0
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   start     : one-cycle transfer request, sampled in IDLE only
//   mode      : 0 = dump, 1 = load (sampled with start)
//   rf_addr   : register-file port-1 address
//   rf_rdata  : register-file port-1 read data (combinational from rf_addr)
//   rf_write  : register-file write enable
//   rf_wdata  : register-file write data (always equals in_data)
//   out_valid / out_ready / out_data : dump stream
//   in_valid  / in_ready  / in_data  : load stream
//   busy      : high while a transfer is in progress
//   done      : one-cycle completion pulse
module regfile_dump_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mode,
    output logic [$clog2(NUM_REGS)-1:0] rf_addr,
    input  logic [DATA_W-1:0]           rf_rdata,
    output logic                        rf_write,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

`ifdef REGFILE_DUMP_LOAD_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1
    } state_t;
`endif

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                out_valid_r, out_valid_s;
    logic [DATA_W-1:0]   out_data_r, out_data_s;
    logic                done_r, done_s;

    // State and output registers; reset acts immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            done_r      <= done_s;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_s = '0;
`ifdef REGFILE_DUMP_LOAD_EN
                    state_s = mode ? LOAD : DUMP;
`else
                    state_s = DUMP;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            DUMP: begin
                if (!out_valid_r) begin
                    // First cycle of a dump: capture entry 0.
                    out_valid_s = 1'b1;
                    out_data_s  = rf_rdata;
                end else if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        out_valid_s = 1'b0;
                        done_s      = 1'b1;
                        idx_s       = '0;
                        state_s     = IDLE;
                    end else begin
                        // rf_addr already looks one entry ahead, so
                        // rf_rdata is the next word to present.
                        idx_s      = idx_r + ONE_IDX;
                        out_data_s = rf_rdata;
                    end
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
`ifdef REGFILE_DUMP_LOAD_EN
            LOAD: begin
                if (in_valid) begin
                    if (idx_r == LAST_IDX) begin
                        done_s  = 1'b1;
                        idx_s   = '0;
                        state_s = IDLE;
                    end else begin
                        idx_s = idx_r + ONE_IDX;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
`endif
            default: begin
                state_s     = IDLE;
                idx_s       = '0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // While a dump word is being presented the read port addresses the
    // following entry, so a handshake can capture it in the same edge.
    // On the last entry this wraps to 0, which is harmless.
    assign rf_addr = ((state_r == DUMP) && out_valid_r) ? (idx_r + ONE_IDX) : idx_r;

`ifdef REGFILE_DUMP_LOAD_EN
    assign in_ready = (state_r == LOAD);
    assign rf_write = in_ready & in_valid;
`else
    logic unused_s;
    assign unused_s = ^{mode, in_valid};
    assign in_ready = 1'b0;
    assign rf_write = 1'b0;
`endif

    assign rf_wdata  = in_data;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign done      = done_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
module tb_regfile_dump_ctrl;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset, start, mode, out_ready, in_valid;
    logic [W-1:0]  in_data, rf_rdata, out_data, rf_wdata;
    logic [AW-1:0] rf_addr;
    logic          rf_write, out_valid, in_ready, busy, done;

    logic [W-1:0]  rf_mem      [N];
    logic [W-1:0]  preset_vals [N];
    logic [W-1:0]  model_regs  [N];
    logic [W-1:0]  load_vals   [N];
    logic          preset_go;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_dump_ctrl #(.NUM_REGS(N), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_write(rf_write),
        .rf_wdata(rf_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done)
    );

    // Behavioural register file attached to the DUT.
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (preset_go) rf_mem <= preset_vals;
        else if (rf_write) rf_mem[rf_addr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_preset();
        @(negedge clk) preset_go = 1'b1;
        @(negedge clk) preset_go = 1'b0;
        model_regs = preset_vals;
    endtask

    // ready_style: 0 always ready, 1 pattern 1,0,0,1,..., 2 random.
    // reset_after >= 0: assert reset once that many handshakes have occurred.
    task automatic run_dump(input int ready_style, input logic mode_bit,
                            input bit extra_start, input int reset_after);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; mode = mode_bit; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        check("dump_busy_on_start", busy, 1'b1);
        check("dump_first_cycle_not_valid", out_valid, 1'b0);
        while (k < N && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("dump_valid", out_valid, 1'b1);
            check("dump_data", out_data, model_regs[k]);
            check("dump_busy", busy, 1'b1);
            check("dump_no_done", done, 1'b0);
            check("dump_no_write", rf_write, 1'b0);
            check("dump_no_in_ready", in_ready, 1'b0);
            start = (extra_start && cyc == 2);
            if (reset_after >= 0 && k == reset_after) begin
                out_ready = 1'b1;
                #2 reset = 1'b1;
                #1;
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_out_data", out_data, 16'h0000);
                check("rst_done", done, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_in_ready", in_ready, 1'b0);
                check("rst_rf_write", rf_write, 1'b0);
                check("rst_rf_addr", rf_addr, 2'd0);
                @(negedge clk);
                check("rst_hold_done", done, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                check("post_rst_done", done, 1'b0);
                check("post_rst_idle", busy, 1'b0);
                return;
            end
            case (ready_style)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) k++;
        end
        check("dump_timeout", (cyc < 100), 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        check("dump_done_pulse", done, 1'b1);
        check("dump_busy_low", busy, 1'b0);
        check("dump_valid_low", out_valid, 1'b0);
        check("dump_data_kept", out_data, model_regs[N-1]);
        @(negedge clk);
        check("dump_done_one_cycle", done, 1'b0);
        check("dump_stays_idle", busy, 1'b0);
    endtask

`ifdef REGFILE_DUMP_LOAD_EN
    task automatic run_load();
        int k;
        int cyc;
        logic v;
        k = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        while (k < N && cyc < 100) begin
            v = ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_data  = v ? load_vals[k] : W'($urandom);
            #1;
            check("load_in_ready", in_ready, 1'b1);
            check("load_rf_write", rf_write, v);
            check("load_rf_addr", rf_addr, AW'(k));
            check("load_rf_wdata", rf_wdata, in_data);
            check("load_no_done", done, 1'b0);
            if (v) begin
                model_regs[k] = load_vals[k];
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        check("load_timeout", (cyc < 100), 1'b1);
        in_valid = 1'b1;
        #1;
        check("load_done_pulse", done, 1'b1);
        check("load_busy_low", busy, 1'b0);
        check("load_in_ready_low", in_ready, 1'b0);
        check("load_idle_no_write", rf_write, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("load_done_one_cycle", done, 1'b0);
        for (int i = 0; i < N; i++) check("load_reg_content", rf_mem[i], model_regs[i]);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0; preset_go = 1'b0;
        #12;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rf_addr", rf_addr, 2'd0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_rf_write", rf_write, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("idle_without_start", busy, 1'b0);

        // Fixed preset, always ready.
        for (int i = 0; i < N; i++) preset_vals[i] = W'((i + 1) * 16'h1111);
        do_preset();
        run_dump(0, 1'b0, 1'b0, -1);
        // Same preset, ready pattern 1,0,0,1,...
        run_dump(1, 1'b0, 1'b0, -1);
        // Random preset, random ready.
        for (int i = 0; i < N; i++) preset_vals[i] = W'($urandom);
        do_preset();
        run_dump(2, 1'b0, 1'b0, -1);
        // start pulsed mid-dump must be ignored.
        run_dump(2, 1'b0, 1'b1, -1);
        // Reset after the second handshake, then a fresh dump from entry 0.
        run_dump(0, 1'b0, 1'b0, 2);
        run_dump(0, 1'b0, 1'b0, -1);

`ifdef REGFILE_DUMP_LOAD_EN
        load_vals[0] = 16'hA0A0; load_vals[1] = 16'hB0B0;
        load_vals[2] = 16'hC0C0; load_vals[3] = 16'hD0D0;
        run_load();
        run_dump(0, 1'b0, 1'b0, -1);
        for (int i = 0; i < N; i++) load_vals[i] = W'($urandom);
        run_load();
        run_dump(2, 1'b0, 1'b0, -1);
`else
        // Without the load feature, mode=1 still dumps and never writes.
        in_valid = 1'b1;
        run_dump(2, 1'b1, 1'b0, -1);
        in_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
